// File: rtl/qwi_regmaster.sv
// rtl/qwi_regmaster.sv - command-stream to qwi_regctrl register-bus initiator
// One outstanding command; out-of-range addresses are answered locally without a bus strobe.
module qwi_regmaster #(
  parameter int REGCNT = 2,
  parameter int AWID   = 11,
  parameter int DWID   = 32,
  parameter int RDLAT  = 1,
  parameter logic [DWID-1:0] ERRDATA = DWID'(32'hDEADBEEF)
) (
  input  logic              reg_clk,
  input  logic              reg_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [DWID/8-1:0] cmd_be,
  input  logic [AWID-1:0]   cmd_addr,
  input  logic [DWID-1:0]   cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_wr,
  output logic              rsp_err,
  output logic [DWID-1:0]   rsp_rdata,
  output logic              busy,
  output logic              reg_ce,
  output logic [DWID/8-1:0] reg_we,
  output logic [AWID-1:0]   reg_addr,
  output logic [DWID-1:0]   reg_wrd,
  input  logic [DWID-1:0]   reg_rdd
);

  localparam int BEW = DWID / 8;
  localparam logic [31:0] REGCNT_W = 32'(REGCNT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic [1:0] lat_cnt;
  logic       wr_q;
  logic       in_range;

  assign in_range = 32'(cmd_addr) < REGCNT_W;

  always_ff @(posedge reg_clk or negedge reg_rst_n) begin
    if (!reg_rst_n) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      wr_q      <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_wr    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
      reg_ce    <= 1'b0;
      reg_we    <= '0;
      reg_addr  <= '0;
      reg_wrd   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_ready && cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            wr_q      <= cmd_wr;
            if (in_range) begin
              // Bus fields are loaded here so they appear together with reg_ce in ISSUE.
              state    <= ISSUE;
              reg_ce   <= 1'b1;
              reg_addr <= cmd_addr;
              reg_we   <= cmd_wr ? cmd_be : {BEW{1'b0}};
              reg_wrd  <= cmd_wr ? cmd_wdata : {DWID{1'b0}};
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_wr    <= cmd_wr;
              rsp_rdata <= ERRDATA;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ISSUE: begin
          reg_ce   <= 1'b0;
          reg_we   <= '0;
          reg_addr <= '0;
          reg_wrd  <= '0;
          if (wr_q) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_wr    <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end else begin
            state   <= WAIT;
            lat_cnt <= 2'(RDLAT - 1);
          end
        end
        WAIT: begin
          if (lat_cnt == 2'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_wr    <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= reg_rdd;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_wr    <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
